// File: rtl/uart_mem_loader_pkg.sv
// Shared constants and state encodings for the UART memory loader.
package uart_mem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b01;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ADDR_H,
    P_ADDR_L,
    P_LEN_H,
    P_LEN_L,
    P_DATA,
    P_CSUM,
    P_ABORT
  } parse_state_t;

  typedef enum logic {
    M_IDLE,
    M_WAIT
  } mem_state_t;

endpackage

// File: rtl/uart_mem_loader_fifo.sv
// Synchronous byte FIFO between uart_rx and the frame parser.
module loader_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [7:0] head_data,
  output logic       empty,
  output logic       overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full;
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop    = pop && !empty;
    // a pop frees the slot the same cycle, so push into a full FIFO is fine then
    do_push   = push && (!full || do_pop);
    overflow  = push && full && !do_pop && !flush;
    head_data = mem_q[rd_ptr_q[AW-1:0]];
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Parses SYNC/ADDR/LEN/payload/CSUM frames from uart_rx and writes each payload
// byte to memory as a second bus master.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_enable,
  input  logic        I_rx_data_ready,
  input  logic [7:0]  I_rx_data,
  input  logic        MEM_ready,
  input  logic        MEM_data_ready,
  output logic        MEM_exec,
  output logic        MEM_write,
  output logic [1:0]  MEM_size,
  output logic [15:0] MEM_addr,
  output logic [15:0] MEM_data_out,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_error
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  parse_state_t  pstate_q, pstate_d;
  mem_state_t    mstate_q, mstate_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   maddr_q, maddr_d;
  logic [15:0]   mdata_q, mdata_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          exec_q, exec_d;
  logic          write_q, write_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_ovf;
  logic [7:0]    fifo_head;
  logic          active, mem_free, timeout;
  logic [15:0]   len_load;

  assign fifo_push  = I_rx_data_ready && I_enable;
  assign fifo_flush = (pstate_q == P_ABORT) || !I_enable;

  loader_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (I_clk),
    .rst      (I_reset),
    .push     (fifo_push),
    .push_data(I_rx_data),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .head_data(fifo_head),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  always_comb begin
    pstate_d = pstate_q;
    mstate_d = mstate_q;
    addr_d   = addr_q;
    len_d    = len_q;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    sum_d    = sum_q;
    write_d  = write_q;
    exec_d   = 1'b0;
    done_d   = 1'b0;
    error_d  = 1'b0;
    fifo_pop = 1'b0;

    active   = (pstate_q != P_IDLE) && (pstate_q != P_ABORT);
    // exec_q is the request cycle itself; the bus is only free once it has retired
    mem_free = (mstate_q == M_IDLE) && !exec_q;
    timeout  = active && (tmo_q == TW'(TIMEOUT_CYCLES));
    tmo_d    = (fifo_push || !active) ? '0 : tmo_q + 1'b1;
    len_load = {len_q[15:8], fifo_head};

    case (mstate_q)
      M_IDLE: if (exec_q) mstate_d = M_WAIT;
      M_WAIT: begin
        if (MEM_data_ready) begin
          mstate_d = M_IDLE;
          write_d  = 1'b0;
        end
      end
      default: mstate_d = M_IDLE;
    endcase

    if (active && (fifo_ovf || timeout)) begin
      error_d  = 1'b1;
      pstate_d = P_ABORT;
    end else if (active && !I_enable) begin
      pstate_d = P_ABORT;
    end else begin
      case (pstate_q)
        P_IDLE: begin
          if (I_enable && !fifo_empty) begin
            fifo_pop = 1'b1;
            if (fifo_head == SYNC_BYTE) begin
              pstate_d = P_ADDR_H;
              sum_d    = '0;
            end
          end
        end
        P_ADDR_H: begin
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            addr_d[15:8] = fifo_head;
            sum_d        = sum_q + fifo_head;
            pstate_d     = P_ADDR_L;
          end
        end
        P_ADDR_L: begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            addr_d[7:0] = fifo_head;
            sum_d       = sum_q + fifo_head;
            pstate_d    = P_LEN_H;
          end
        end
        P_LEN_H: begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            len_d[15:8] = fifo_head;
            sum_d       = sum_q + fifo_head;
            pstate_d    = P_LEN_L;
          end
        end
        P_LEN_L: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            len_d    = len_load;
            sum_d    = sum_q + fifo_head;
            pstate_d = (len_load == 16'h0000) ? P_CSUM : P_DATA;
          end
        end
        P_DATA: begin
          if (len_q == 16'h0000) begin
            if (mem_free) pstate_d = P_CSUM;
          end else if (!fifo_empty && mem_free && MEM_ready) begin
            fifo_pop = 1'b1;
            exec_d   = 1'b1;
            write_d  = 1'b1;
            maddr_d  = addr_q;
            mdata_d  = {8'h00, fifo_head};
            sum_d    = sum_q + fifo_head;
            addr_d   = addr_q + 16'd1;
            len_d    = len_q - 16'd1;
          end
        end
        P_CSUM: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            if (fifo_head == sum_q) done_d = 1'b1;
            else                    error_d = 1'b1;
            pstate_d = P_IDLE;
          end
        end
        P_ABORT: begin
          if (mem_free) pstate_d = P_IDLE;
        end
        default: pstate_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      pstate_q <= P_IDLE;
      mstate_q <= M_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      maddr_q  <= '0;
      mdata_q  <= '0;
      sum_q    <= '0;
      tmo_q    <= '0;
      exec_q   <= 1'b0;
      write_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      mstate_q <= mstate_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
      sum_q    <= sum_d;
      tmo_q    <= tmo_d;
      exec_q   <= exec_d;
      write_q  <= write_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign MEM_exec     = exec_q;
  assign MEM_write    = write_q;
  assign MEM_size     = MEM_SIZE_BYTE;
  assign MEM_addr     = maddr_q;
  assign MEM_data_out = mdata_q;
  assign O_busy       = (pstate_q != P_IDLE);
  assign O_done       = done_q;
  assign O_error      = error_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader with a small memory responder model.
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        mem_ready = 1'b1;
  logic        mem_data_ready = 1'b0;
  logic        mem_exec, mem_write;
  logic [1:0]  mem_size;
  logic [15:0] mem_addr, mem_data_out;
  logic        busy, done, err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic stall = 1'b0;

  // responder / monitor state (written only by the negedge process)
  int resp_cnt = 0;
  logic prev_exec = 1'b0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, viol_cnt = 0;
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int exec_cyc[$];
  int sent_cyc[$];

  uart_mem_loader #(
    .SYNC_BYTE     (8'hA5),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .I_clk          (clk),
    .I_reset        (rst),
    .I_enable       (en),
    .I_rx_data_ready(rx_rdy),
    .I_rx_data      (rx_data),
    .MEM_ready      (mem_ready),
    .MEM_data_ready (mem_data_ready),
    .MEM_exec       (mem_exec),
    .MEM_write      (mem_write),
    .MEM_size       (mem_size),
    .MEM_addr       (mem_addr),
    .MEM_data_out   (mem_data_out),
    .O_busy         (busy),
    .O_done         (done),
    .O_error        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Responder: completes each write 3 cycles after MEM_exec; logs traffic.
  always @(negedge clk) begin
    mem_data_ready = 1'b0;
    if (rst) begin
      resp_cnt  = 0;
      prev_exec = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
      if (mem_exec) begin
        if (prev_exec || resp_cnt != 0 || mem_write !== 1'b1 || mem_size !== 2'b00) begin
          viol_cnt++;
          $display("protocol: exec at cycle %0d prev=%0b outstanding=%0d write=%0b size=%b",
                   cyc, prev_exec, resp_cnt, mem_write, mem_size);
        end
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_data_out);
        exec_cyc.push_back(cyc);
        resp_cnt = 2;
      end else if (resp_cnt > 0) begin
        if (mem_addr !== wr_addr[$] || mem_data_out !== wr_data[$] || mem_write !== 1'b1) begin
          viol_cnt++;
          $display("protocol: bus not held at cycle %0d addr=%h data=%h write=%0b",
                   cyc, mem_addr, mem_data_out, mem_write);
        end
        resp_cnt--;
        if (resp_cnt == 0) mem_data_ready = 1'b1;
      end
      prev_exec = mem_exec;
    end
    mem_ready = !stall && resp_cnt == 0 && !mem_exec;
  end

  function automatic logic [15:0] wa(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 16'hxxxx;
  endfunction

  function automatic logic [15:0] wd(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 16'hxxxx;
  endfunction

  task automatic send_bytes(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) begin
      rx_data = bytes[i];
      rx_rdy  = 1'b1;
      sent_cyc.push_back(cyc);
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit timed_out);
    int n = 0;
    @(negedge clk);
    while ((busy || resp_cnt != 0 || mem_exec) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    timed_out = busy || resp_cnt != 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_exec, mem_write, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: exec/write/busy/done/error=%b required 00000",
               {mem_exec, mem_write, busy, done, err});
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_data_out !== 16'h0 || mem_size !== 2'b00) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h size=%b required 0000 0000 00",
               mem_addr, mem_data_out, mem_size);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_exec !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%0b exec=%0b required 0 0", busy, mem_exec);
    end
  endtask

  // checksum covers address, length and payload bytes (8-bit wrap)
  task automatic test_basic_write();
    logic [7:0] f[$];
    bit to;
    int w0 = wr_addr.size(), d0 = done_cnt, e0 = err_cnt, v0 = viol_cnt, s0 = sent_cyc.size();
    f = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h36};
    send_bytes(f, 2);
    wait_idle(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_idle: busy=%0b required 0", busy); end
    checks++;
    if (wr_addr.size() - w0 != 2) begin
      errors++; $display("FAIL basic_count: writes=%0d required 2", wr_addr.size() - w0);
    end
    checks++;
    if (wa(w0) !== 16'h0100 || wd(w0) !== 16'h0011) begin
      errors++; $display("FAIL basic_wr0: %h=%h required 0100=0011", wa(w0), wd(w0));
    end
    checks++;
    if (wa(w0 + 1) !== 16'h0101 || wd(w0 + 1) !== 16'h0022) begin
      errors++; $display("FAIL basic_wr1: %h=%h required 0101=0022", wa(w0 + 1), wd(w0 + 1));
    end
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++; $display("FAIL basic_status: done=%0d error=%0d required 1 0",
                         done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (exec_cyc.size() <= w0 || exec_cyc[w0] - sent_cyc[s0 + 5] != 2) begin
      errors++; $display("FAIL basic_latency: strobe->exec=%0d cycles required 2",
                         (exec_cyc.size() > w0) ? exec_cyc[w0] - sent_cyc[s0 + 5] : -1);
    end
    checks++;
    if (viol_cnt != v0) begin
      errors++; $display("FAIL basic_protocol: violations=%0d required 0", viol_cnt - v0);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f[$];
    bit to;
    int w0 = wr_addr.size(), d0 = done_cnt, e0 = err_cnt;
    f = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h35};
    send_bytes(f, 2);
    wait_idle(200, to);
    checks++;
    if (to || wr_addr.size() - w0 != 2) begin
      errors++; $display("FAIL badcs_writes: writes=%0d busy=%0b required 2 0",
                         wr_addr.size() - w0, busy);
    end
    checks++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      errors++; $display("FAIL badcs_status: done=%0d error=%0d required 0 1",
                         done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_addr_wrap();
    logic [7:0] f[$];
    bit to;
    int w0 = wr_addr.size(), d0 = done_cnt, e0 = err_cnt;
    f = {8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h65};
    send_bytes(f, 1);
    wait_idle(200, to);
    checks++;
    if (to || wa(w0) !== 16'hFFFF || wd(w0) !== 16'h00AA) begin
      errors++; $display("FAIL wrap_wr0: %h=%h required FFFF=00AA", wa(w0), wd(w0));
    end
    checks++;
    if (wa(w0 + 1) !== 16'h0000 || wd(w0 + 1) !== 16'h00BB) begin
      errors++; $display("FAIL wrap_wr1: %h=%h required 0000=00BB", wa(w0 + 1), wd(w0 + 1));
    end
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++; $display("FAIL wrap_status: done=%0d error=%0d required 1 0",
                         done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] f[$];
    bit to;
    int w0 = wr_addr.size(), d0 = done_cnt, e0 = err_cnt;
    stall = 1'b1;
    repeat (2) @(negedge clk);
    f = {8'hA5, 8'h10, 8'h00, 8'h00, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_bytes(f, 1);
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++; $display("FAIL ovf_error: error pulses=%0d required 1", err_cnt - e0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ovf_busy: busy=%0b required 0", busy);
    end
    stall = 1'b0;
    wait_idle(100, to);
    checks++;
    if (to || wr_addr.size() != w0 || done_cnt != d0 || err_cnt - e0 != 1) begin
      errors++; $display("FAIL ovf_after: writes=%0d done=%0d error=%0d required 0 0 1",
                         wr_addr.size() - w0, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] f[$];
    bit to;
    int n = 0;
    int w0 = wr_addr.size(), d0 = done_cnt, e0 = err_cnt;
    f = {8'hA5, 8'h02, 8'h00};
    send_bytes(f, 1);
    repeat (150) @(negedge clk);
    checks++;
    if (err_cnt != e0 || busy !== 1'b1) begin
      errors++; $display("FAIL tmo_early: error=%0d busy=%0b required 0 1", err_cnt - e0, busy);
    end
    while (err_cnt == e0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++; $display("FAIL tmo_error: error pulses=%0d required 1", err_cnt - e0);
    end
    wait_idle(50, to);
    checks++;
    if (to || busy !== 1'b0 || wr_addr.size() != w0 || done_cnt != d0) begin
      errors++; $display("FAIL tmo_after: busy=%0b writes=%0d done=%0d required 0 0 0",
                         busy, wr_addr.size() - w0, done_cnt - d0);
    end
  endtask

  task automatic test_zero_length();
    logic [7:0] f[$];
    bit to;
    int w0 = wr_addr.size(), d0 = done_cnt, e0 = err_cnt;
    f = {8'h00, 8'h13, 8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h10};
    send_bytes(f, 1);
    wait_idle(100, to);
    checks++;
    if (to || done_cnt - d0 != 1 || err_cnt != e0) begin
      errors++; $display("FAIL zlen_status: done=%0d error=%0d required 1 0",
                         done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (wr_addr.size() != w0) begin
      errors++; $display("FAIL zlen_writes: writes=%0d required 0", wr_addr.size() - w0);
    end
  endtask

  task automatic test_enable_abort();
    logic [7:0] f[$];
    int d0 = done_cnt, e0 = err_cnt, w0 = wr_addr.size();
    f = {8'hA5, 8'h03, 8'h00};
    send_bytes(f, 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL en_start: busy=%0b required 1", busy);
    end
    en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err_cnt != e0 || done_cnt != d0) begin
      errors++; $display("FAIL en_abort: busy=%0b error=%0d done=%0d required 0 0 0",
                         busy, err_cnt - e0, done_cnt - d0);
    end
    f = {8'hA5};
    send_bytes(f, 1);
    en = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_addr.size() != w0) begin
      errors++; $display("FAIL en_ignored: busy=%0b writes=%0d required 0 0",
                         busy, wr_addr.size() - w0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f[$];
    bit to;
    int w0 = wr_addr.size(), d0 = done_cnt, e0 = err_cnt, v0 = viol_cnt;
    f = {8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h5A, 8'h7B,
         8'hA5, 8'h00, 8'h21, 8'h00, 8'h01, 8'hC3, 8'hE5};
    send_bytes(f, 1);
    wait_idle(200, to);
    checks++;
    if (to || wa(w0) !== 16'h0020 || wd(w0) !== 16'h005A) begin
      errors++; $display("FAIL b2b_wr0: %h=%h required 0020=005A", wa(w0), wd(w0));
    end
    checks++;
    if (wa(w0 + 1) !== 16'h0021 || wd(w0 + 1) !== 16'h00C3) begin
      errors++; $display("FAIL b2b_wr1: %h=%h required 0021=00C3", wa(w0 + 1), wd(w0 + 1));
    end
    checks++;
    if (done_cnt - d0 != 2 || err_cnt != e0) begin
      errors++; $display("FAIL b2b_status: done=%0d error=%0d required 2 0",
                         done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (viol_cnt != v0 || both_cnt != 0) begin
      errors++; $display("FAIL b2b_protocol: violations=%0d done_with_error=%0d required 0 0",
                         viol_cnt - v0, both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_bad_checksum();
    test_addr_wrap();
    test_overflow();
    test_timeout();
    test_zero_length();
    test_enable_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1);
  end

endmodule
